// File: rtl/spi_cmd_sequencer.sv
// Turns the SPI slave byte stream into register-bank accesses. The first byte of each
// chip-select frame is a command (bit7 = read, low bits = start address), then one access per byte.
module spi_cmd_sequencer #(
    parameter int unsigned ADDR_BITS  = 7,
    parameter int unsigned RD_TIMEOUT = 4,
    parameter logic [7:0]  ERR_BYTE   = 8'hEE,
    parameter logic [7:0]  IDLE_BYTE  = 8'hA5
) (
    input  logic                 MClk,
    input  logic                 USPI_Rst_n,
    input  logic                 Spi_Csel_Active,
    input  logic                 Spi_Start_Msg,
    input  logic [7:0]           Spi_Rx_Byte,
    input  logic                 Spi_Rx_Valid,
    output logic [7:0]           Spi_Tx_Byte,
    output logic                 Spi_Tx_Load,
    output logic [ADDR_BITS-1:0] Reg_Addr,
    output logic [7:0]           Reg_Wdata,
    output logic                 Reg_Wr_Strobe,
    output logic                 Reg_Rd_Strobe,
    input  logic [7:0]           Reg_Rdata,
    input  logic                 Reg_Rd_Valid,
    output logic                 Busy,
    output logic [7:0]           Frame_Count,
    output logic [7:0]           Err_Count
);

    localparam int unsigned          CNT_BITS = $clog2(RD_TIMEOUT + 1);
    localparam logic [CNT_BITS-1:0]  TMO_LAST = CNT_BITS'(RD_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WR,
        S_RD_REQ,
        S_RD_WAIT,
        S_RD_HOLD
    } state_t;

    state_t               state, state_nxt;
    logic [ADDR_BITS-1:0] addr, addr_nxt, reg_addr_nxt;
    logic [CNT_BITS-1:0]  tmo_cnt, tmo_cnt_nxt;
    logic [7:0]           tx_byte_nxt, wdata_nxt;
    logic                 tx_load_nxt, wr_nxt, rd_nxt;
    logic [1:0]           err_add;
    logic [8:0]           err_sum;

    assign Busy    = (state != S_IDLE);
    assign err_sum = {1'b0, Err_Count} + {7'd0, err_add};

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path can infer a latch.
        state_nxt    = state;
        addr_nxt     = addr;
        reg_addr_nxt = Reg_Addr;
        wdata_nxt    = Reg_Wdata;
        tmo_cnt_nxt  = tmo_cnt;
        tx_byte_nxt  = Spi_Tx_Byte;
        tx_load_nxt  = 1'b0;
        wr_nxt       = 1'b0;
        rd_nxt       = 1'b0;
        err_add      = 2'd0;

        // A new start pulse outranks everything; a dropped chip select outranks any byte.
        if (Spi_Start_Msg) begin
            state_nxt   = S_CMD;
            tx_byte_nxt = IDLE_BYTE;
            err_add     = {1'b0, (state != S_IDLE)};
        end else if (!Spi_Csel_Active) begin
            state_nxt   = S_IDLE;
            tx_byte_nxt = IDLE_BYTE;
            err_add     = {1'b0, (state == S_CMD)};
        end else begin
            unique case (state)
                S_IDLE: state_nxt = S_IDLE;
                S_CMD: begin
                    if (Spi_Rx_Valid) begin
                        addr_nxt = Spi_Rx_Byte[ADDR_BITS-1:0];
                        if (Spi_Rx_Byte[7]) begin
                            reg_addr_nxt = Spi_Rx_Byte[ADDR_BITS-1:0];
                            rd_nxt       = 1'b1;
                            state_nxt    = S_RD_REQ;
                        end else begin
                            state_nxt = S_WR;
                        end
                    end
                end
                S_WR: begin
                    if (Spi_Rx_Valid) begin
                        wr_nxt       = 1'b1;
                        reg_addr_nxt = addr;
                        wdata_nxt    = Spi_Rx_Byte;
                        addr_nxt     = addr + 1'b1;
                    end
                end
                S_RD_REQ: begin
                    tmo_cnt_nxt = '0;
                    state_nxt   = S_RD_WAIT;
                    err_add     = {1'b0, Spi_Rx_Valid};
                end
                S_RD_WAIT: begin
                    // A host byte and a timeout can land together; both are counted.
                    if (Reg_Rd_Valid) begin
                        tx_byte_nxt = Reg_Rdata;
                        tx_load_nxt = 1'b1;
                        addr_nxt    = addr + 1'b1;
                        state_nxt   = S_RD_HOLD;
                        err_add     = {1'b0, Spi_Rx_Valid};
                    end else if (tmo_cnt == TMO_LAST) begin
                        tx_byte_nxt = ERR_BYTE;
                        tx_load_nxt = 1'b1;
                        addr_nxt    = addr + 1'b1;
                        state_nxt   = S_RD_HOLD;
                        err_add     = 2'd1 + {1'b0, Spi_Rx_Valid};
                    end else begin
                        tmo_cnt_nxt = tmo_cnt + 1'b1;
                        err_add     = {1'b0, Spi_Rx_Valid};
                    end
                end
                S_RD_HOLD: begin
                    if (Spi_Rx_Valid) begin
                        reg_addr_nxt = addr;
                        rd_nxt       = 1'b1;
                        state_nxt    = S_RD_REQ;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge MClk or negedge USPI_Rst_n) begin
        if (!USPI_Rst_n) begin
            state         <= S_IDLE;
            addr          <= '0;
            tmo_cnt       <= '0;
            Reg_Addr      <= '0;
            Reg_Wdata     <= '0;
            Reg_Wr_Strobe <= 1'b0;
            Reg_Rd_Strobe <= 1'b0;
            Spi_Tx_Byte   <= IDLE_BYTE;
            Spi_Tx_Load   <= 1'b0;
            Frame_Count   <= '0;
            Err_Count     <= '0;
        end else begin
            state         <= state_nxt;
            addr          <= addr_nxt;
            tmo_cnt       <= tmo_cnt_nxt;
            Reg_Addr      <= reg_addr_nxt;
            Reg_Wdata     <= wdata_nxt;
            Reg_Wr_Strobe <= wr_nxt;
            Reg_Rd_Strobe <= rd_nxt;
            Spi_Tx_Byte   <= tx_byte_nxt;
            Spi_Tx_Load   <= tx_load_nxt;
            if (Spi_Start_Msg) begin
                Frame_Count <= Frame_Count + 1'b1;
            end
            Err_Count     <= err_sum[8] ? 8'hFF : err_sum[7:0];
        end
    end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Directed bench for spi_cmd_sequencer: drives SPI byte frames, models a register bank that
// answers reads with 0x40 + address, and compares strobes, MISO loads and counters.
module tb_spi_cmd_sequencer;

    localparam int RD_TIMEOUT = 4;

    logic       MClk = 1'b0;
    logic       USPI_Rst_n = 1'b0;
    logic       Spi_Csel_Active = 1'b0;
    logic       Spi_Start_Msg = 1'b0;
    logic [7:0] Spi_Rx_Byte = 8'h00;
    logic       Spi_Rx_Valid = 1'b0;
    logic [7:0] Spi_Tx_Byte;
    logic       Spi_Tx_Load;
    logic [6:0] Reg_Addr;
    logic [7:0] Reg_Wdata;
    logic       Reg_Wr_Strobe;
    logic       Reg_Rd_Strobe;
    logic [7:0] Reg_Rdata = 8'h00;
    logic       Reg_Rd_Valid = 1'b0;
    logic       Busy;
    logic [7:0] Frame_Count;
    logic [7:0] Err_Count;

    spi_cmd_sequencer dut (
        .MClk            (MClk),
        .USPI_Rst_n      (USPI_Rst_n),
        .Spi_Csel_Active (Spi_Csel_Active),
        .Spi_Start_Msg   (Spi_Start_Msg),
        .Spi_Rx_Byte     (Spi_Rx_Byte),
        .Spi_Rx_Valid    (Spi_Rx_Valid),
        .Spi_Tx_Byte     (Spi_Tx_Byte),
        .Spi_Tx_Load     (Spi_Tx_Load),
        .Reg_Addr        (Reg_Addr),
        .Reg_Wdata       (Reg_Wdata),
        .Reg_Wr_Strobe   (Reg_Wr_Strobe),
        .Reg_Rd_Strobe   (Reg_Rd_Strobe),
        .Reg_Rdata       (Reg_Rdata),
        .Reg_Rd_Valid    (Reg_Rd_Valid),
        .Busy            (Busy),
        .Frame_Count     (Frame_Count),
        .Err_Count       (Err_Count)
    );

    always #10 MClk = ~MClk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observed traffic, sampled on the falling edge while registered outputs are stable.
    logic [14:0] wr_q[$];
    logic [6:0]  rd_q[$];
    logic [7:0]  tx_q[$];
    int          cyc = 0;
    int          last_rd_cyc = 0;
    int          last_tx_cyc = 0;
    int          bank_delay = 0;
    int          bank_cd = 0;
    logic [6:0]  bank_addr = '0;
    bit          overlap_seen = 1'b0;
    bit          load_idle_seen = 1'b0;

    // Bank model: answers a read strobe bank_delay cycles later (0 = never answers).
    always @(negedge MClk) begin
        cyc++;
        Reg_Rd_Valid = 1'b0;
        if (bank_cd > 0) begin
            bank_cd--;
            if (bank_cd == 0) begin
                Reg_Rd_Valid = 1'b1;
                Reg_Rdata    = 8'h40 + {1'b0, bank_addr};
            end
        end
        if (Reg_Rd_Strobe) begin
            rd_q.push_back(Reg_Addr);
            last_rd_cyc = cyc;
            if (bank_delay > 0) begin
                bank_cd   = bank_delay;
                bank_addr = Reg_Addr;
            end
        end
        if (Reg_Wr_Strobe) wr_q.push_back({Reg_Addr, Reg_Wdata});
        if (Spi_Tx_Load) begin
            tx_q.push_back(Spi_Tx_Byte);
            last_tx_cyc = cyc;
            if (!Busy) load_idle_seen = 1'b1;
        end
        if (Reg_Wr_Strobe && Reg_Rd_Strobe) overlap_seen = 1'b1;
    end

    task automatic do_reset();
        @(posedge MClk);
        #2;
        USPI_Rst_n      = 1'b0;
        Spi_Csel_Active = 1'b0;
        Spi_Start_Msg   = 1'b0;
        Spi_Rx_Valid    = 1'b0;
        Spi_Rx_Byte     = 8'h00;
        bank_delay      = 0;
        wr_q.delete();
        rd_q.delete();
        tx_q.delete();
        repeat (2) @(negedge MClk);
        USPI_Rst_n = 1'b1;
        @(negedge MClk);
    endtask

    task automatic start_frame();
        Spi_Csel_Active = 1'b1;
        Spi_Start_Msg   = 1'b1;
        @(negedge MClk);
        Spi_Start_Msg = 1'b0;
        @(negedge MClk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        Spi_Rx_Byte  = b;
        Spi_Rx_Valid = 1'b1;
        @(negedge MClk);
        Spi_Rx_Valid = 1'b0;
        repeat (12) @(negedge MClk);
    endtask

    task automatic end_frame();
        Spi_Csel_Active = 1'b0;
        repeat (3) @(negedge MClk);
    endtask

    initial begin
        // Reset values, sampled while reset is still asserted.
        repeat (2) @(negedge MClk);
        check("rst_tx_byte", Spi_Tx_Byte, 8'hA5);
        check("rst_tx_load", Spi_Tx_Load, 0);
        check("rst_addr", Reg_Addr, 0);
        check("rst_wdata", Reg_Wdata, 0);
        check("rst_strobes", {Reg_Wr_Strobe, Reg_Rd_Strobe}, 0);
        check("rst_busy", Busy, 0);
        check("rst_counts", {Frame_Count, Err_Count}, 0);

        // 1: write frame 05,11,22,33 -> writes at 5,6,7.
        do_reset();
        start_frame();
        check("t1_busy_cmd", Busy, 1);
        send_byte(8'h05);
        Spi_Rx_Byte  = 8'h11;
        Spi_Rx_Valid = 1'b1;
        @(negedge MClk);
        Spi_Rx_Valid = 1'b0;
        check("t1_wr_latency", Reg_Wr_Strobe, 1);
        check("t1_wr_addr_now", Reg_Addr, 7'h05);
        repeat (12) @(negedge MClk);
        send_byte(8'h22);
        send_byte(8'h33);
        end_frame();
        check("t1_wr_cnt", wr_q.size(), 3);
        check("t1_wr0", wr_q[0], {7'h05, 8'h11});
        check("t1_wr1", wr_q[1], {7'h06, 8'h22});
        check("t1_wr2", wr_q[2], {7'h07, 8'h33});
        check("t1_frames", Frame_Count, 1);
        check("t1_errs", Err_Count, 0);
        check("t1_no_loads", tx_q.size(), 0);

        // 2: read frame 0x83 + 3 dummies, bank answers 2 cycles after each strobe.
        do_reset();
        bank_delay = 2;
        start_frame();
        send_byte(8'h83);
        for (int i = 0; i < 3; i++) send_byte(8'h00);
        check("t2_rd_cnt", rd_q.size(), 4);
        check("t2_tx_cnt", tx_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_rd_addr%0d", i), rd_q[i], 3 + i);
            check($sformatf("t2_tx_byte%0d", i), tx_q[i], 8'h43 + i);
        end
        // Load follows the valid by one cycle, valid follows the strobe by bank_delay.
        check("t2_load_latency", last_tx_cyc - last_rd_cyc, 3);
        check("t2_errs", Err_Count, 0);
        end_frame();
        check("t2_idle_byte", Spi_Tx_Byte, 8'hA5);

        // 3: write from 0x7E wraps to 0x00 without error.
        do_reset();
        start_frame();
        send_byte(8'h7E);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        end_frame();
        check("t3_wr_cnt", wr_q.size(), 3);
        check("t3_wr0", wr_q[0], {7'h7E, 8'h01});
        check("t3_wr1", wr_q[1], {7'h7F, 8'h02});
        check("t3_wr2", wr_q[2], {7'h00, 8'h03});
        check("t3_errs", Err_Count, 0);

        // 4: read timeout loads ERR_BYTE, next slot reads addr+1.
        do_reset();
        start_frame();
        send_byte(8'h88);
        check("t4_tx_cnt", tx_q.size(), 1);
        check("t4_err_byte", tx_q[0], 8'hEE);
        check("t4_errs", Err_Count, 1);
        // Worst case is 3 + RD_TIMEOUT from the command byte; the strobe sits one cycle in.
        check("t4_tmo_latency", last_tx_cyc - last_rd_cyc, RD_TIMEOUT + 2);
        bank_delay = 2;
        send_byte(8'h00);
        check("t4_retry_addr", rd_q[1], 7'h09);
        check("t4_retry_byte", tx_q[1], 8'h49);
        check("t4_errs_after", Err_Count, 1);
        end_frame();

        // 5: CSEL drops the cycle after the read strobe; the late valid is ignored.
        do_reset();
        bank_delay = 3;
        start_frame();
        Spi_Rx_Byte  = 8'h90;
        Spi_Rx_Valid = 1'b1;
        @(negedge MClk);
        Spi_Rx_Valid = 1'b0;
        check("t5_rd_latency", Reg_Rd_Strobe, 1);
        Spi_Csel_Active = 1'b0;
        repeat (8) @(negedge MClk);
        check("t5_rd_cnt", rd_q.size(), 1);
        check("t5_no_load", tx_q.size(), 0);
        check("t5_idle_byte", Spi_Tx_Byte, 8'hA5);
        check("t5_busy", Busy, 0);
        check("t5_errs", Err_Count, 0);

        // 6: restart after a write command, then cmd 0x10 with one data byte.
        do_reset();
        start_frame();
        send_byte(8'h20);
        start_frame();
        send_byte(8'h10);
        send_byte(8'hAB);
        end_frame();
        check("t6_wr_cnt", wr_q.size(), 1);
        check("t6_wr0", wr_q[0], {7'h10, 8'hAB});
        check("t6_errs", Err_Count, 1);
        check("t6_frames", Frame_Count, 2);

        // Aborted frame: CSEL drops in CMD before any byte.
        do_reset();
        start_frame();
        end_frame();
        check("abort_errs", Err_Count, 1);
        check("abort_busy", Busy, 0);

        // Host too fast: second byte arrives while the read is still requesting.
        do_reset();
        bank_delay = 2;
        start_frame();
        Spi_Rx_Byte  = 8'h81;
        Spi_Rx_Valid = 1'b1;
        @(negedge MClk);
        Spi_Rx_Byte = 8'h00;
        @(negedge MClk);
        Spi_Rx_Valid = 1'b0;
        repeat (12) @(negedge MClk);
        check("fast_errs", Err_Count, 1);
        check("fast_rd_cnt", rd_q.size(), 1);
        check("fast_tx", tx_q[0], 8'h41);
        check("fast_busy", Busy, 1);
        end_frame();

        // Byte and CSEL drop in the same cycle: no write.
        do_reset();
        start_frame();
        send_byte(8'h30);
        Spi_Rx_Byte     = 8'h77;
        Spi_Rx_Valid    = 1'b1;
        Spi_Csel_Active = 1'b0;
        @(negedge MClk);
        Spi_Rx_Valid = 1'b0;
        repeat (3) @(negedge MClk);
        check("drop_no_wr", wr_q.size(), 0);
        check("drop_busy", Busy, 0);

        // Async reset while a write strobe is high.
        do_reset();
        start_frame();
        send_byte(8'h40);
        Spi_Rx_Byte  = 8'h5A;
        Spi_Rx_Valid = 1'b1;
        @(negedge MClk);
        Spi_Rx_Valid = 1'b0;
        check("arst_pre_strobe", Reg_Wr_Strobe, 1);
        #1;
        USPI_Rst_n = 1'b0;
        #1;
        check("arst_strobe", Reg_Wr_Strobe, 0);
        check("arst_addr", Reg_Addr, 0);
        check("arst_tx_byte", Spi_Tx_Byte, 8'hA5);
        check("arst_busy", Busy, 0);
        check("arst_frames", Frame_Count, 0);
        Spi_Csel_Active = 1'b0;
        repeat (2) @(negedge MClk);
        USPI_Rst_n = 1'b1;
        @(negedge MClk);

        check("never_both_strobes", overlap_seen, 0);
        check("no_load_in_idle", load_idle_seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
